// File: rtl/biquad8_coeff_loader_pkg.sv
// Shared types and constants for the biquad8 coefficient loader.
package biquad8_loader_pkg;

    localparam int unsigned SIDX_W   = 5;
    localparam int unsigned COEF_W   = 18;
    localparam int unsigned WB_ADR_W = 7;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;
    localparam int unsigned COUNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        UPD   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Register map of the biquad8 filter block
    localparam logic [WB_ADR_W-1:0] ADR_UPDATE  = 7'h00;
    localparam logic [WB_ADR_W-1:0] ADR_FIR     = 7'h04;
    localparam logic [WB_ADR_W-1:0] ADR_IIR     = 7'h08;
    localparam logic [WB_ADR_W-1:0] ADR_POLEFIR = 7'h10;

    localparam logic [WB_DAT_W-1:0] UPDATE_DATA = 32'h0000_0001;
    localparam logic [WB_SEL_W-1:0] SEL_ALL     = 4'hF;

    // One WISHBONE write request as held on the bus
    typedef struct packed {
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
    } wb_req_t;

    // Register index to byte address
    function automatic logic [WB_ADR_W-1:0] byte_adr(input logic [SIDX_W-1:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/biquad8_coeff_loader_if.sv
// WISHBONE initiator-side bus bundle for the coefficient loader.
interface biquad8_coeff_loader_if;
    import biquad8_loader_pkg::*;

    logic                wb_cyc_o;
    logic                wb_stb_o;
    logic                wb_we_o;
    logic [WB_ADR_W-1:0] wb_adr_o;
    logic [WB_DAT_W-1:0] wb_dat_o;
    logic [WB_SEL_W-1:0] wb_sel_o;
    logic                wb_ack_i;
    logic                wb_err_i;
    logic                wb_rty_i;
    logic [WB_DAT_W-1:0] wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
    );

endinterface

// File: rtl/biquad8_coeff_loader.sv
// Streams coefficient beats into biquad8 registers over WISHBONE, optionally
// followed by an update-strobe write. Optional ack timeout: BIQUAD8_LOADER_TIMEOUT_EN.
module biquad8_coeff_loader
    import biquad8_loader_pkg::*;
#(
    parameter bit          UPDATE_ON_LAST = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    biquad8_coeff_loader_if.master wb,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [SIDX_W-1:0]      s_adr_i,
    input  logic [COEF_W-1:0]      s_dat_i,
    input  logic                   s_last_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [COUNT_W-1:0]     count_o
);

    state_e             state_q, state_d;
    wb_req_t            req_q, req_d;
    logic               cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic               last_q, last_d, first_q, first_d;
    logic               ready_q, ready_d, busy_q, busy_d;
    logic               done_q, done_d, err_q, err_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               accept_c, ack_c, err_c, rty_c, to_hit_c, fail_c;
    logic               issue_c, drop_c;
    logic               unused_dat;

    // Bus responses only count while a strobed cycle is in flight
    assign accept_c   = s_valid_i && ready_q;
    assign ack_c      = cyc_q && stb_q && wb.wb_ack_i;
    assign err_c      = cyc_q && stb_q && wb.wb_err_i;
    assign rty_c      = cyc_q && stb_q && wb.wb_rty_i;
    assign fail_c     = err_c || (to_hit_c && !ack_c);
    assign unused_dat = ^wb.wb_dat_i;

`ifdef BIQUAD8_LOADER_TIMEOUT_EN
    localparam int unsigned      TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Cycles the bus has been held since the current write was first issued
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (issue_c) begin
            to_cnt_d = '0;
        end else if (cyc_q && (to_cnt_q != '1)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    // Timeout counter register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) to_cnt_q <= '0;
        else          to_cnt_q <= to_cnt_d;
    end

    assign to_hit_c = cyc_q && (to_cnt_q >= TO_LIMIT);
`else
    localparam int unsigned TIMEOUT_UNUSED = TIMEOUT_CYCLES;
    logic unused_issue;
    assign unused_issue = issue_c;
    assign to_hit_c     = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            last_q  <= 1'b0;
            first_q <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            last_q  <= last_d;
            first_q <= first_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        last_d  = last_q;
        first_d = first_q;
        done_d  = 1'b0;
        err_d   = err_q;
        count_d = count_q;
        issue_c = 1'b0;
        drop_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d   = WRITE;
                    last_d    = s_last_i;
                    first_d   = 1'b0;
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    we_d      = 1'b1;
                    req_d.adr = byte_adr(s_adr_i);
                    req_d.dat = WB_DAT_W'(s_dat_i);
                    req_d.sel = SEL_ALL;
                    issue_c   = 1'b1;
                    if (first_q) begin
                        err_d   = 1'b0;
                        count_d = '0;
                    end
                end
            end
            WRITE: begin
                if (!stb_q) begin
                    stb_d = 1'b1;
                end else if (fail_c) begin
                    drop_c  = 1'b1;
                    err_d   = 1'b1;
                    state_d = last_q ? IDLE : DRAIN;
                    first_d = last_q;
                end else if (ack_c) begin
                    drop_c = 1'b1;
                    if (count_q != '1) count_d = count_q + COUNT_W'(1);
                    if (last_q && UPDATE_ON_LAST) begin
                        state_d = UPD;
                    end else begin
                        state_d = IDLE;
                        done_d  = last_q;
                        first_d = last_q;
                    end
                end else if (rty_c) begin
                    stb_d = 1'b0;
                end
            end
            UPD: begin
                if (!cyc_q) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    req_d   = '{adr: ADR_UPDATE, dat: UPDATE_DATA, sel: SEL_ALL};
                    issue_c = 1'b1;
                end else if (!stb_q) begin
                    stb_d = 1'b1;
                end else if (fail_c) begin
                    drop_c  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                    first_d = 1'b1;
                end else if (ack_c) begin
                    drop_c  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    first_d = 1'b1;
                end else if (rty_c) begin
                    stb_d = 1'b0;
                end
            end
            DRAIN: begin
                if (accept_c && s_last_i) begin
                    state_d = IDLE;
                    first_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (drop_c) begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            we_d  = 1'b0;
            req_d = '0;
        end

        ready_d = (state_d == IDLE) || (state_d == DRAIN);
        busy_d  = (state_d != IDLE);
    end

    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = stb_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_adr_o = req_q.adr;
    assign wb.wb_dat_o = req_q.dat;
    assign wb.wb_sel_o = req_q.sel;
    assign s_ready_o   = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Self-checking bench for biquad8_coeff_loader: directed scenarios plus
// randomized frames checked against a write-list model of the frame rules.
module tb_biquad8_coeff_loader;
    import biquad8_loader_pkg::*;

    localparam int unsigned TB_TIMEOUT = 8;
    localparam int K_ACK  = 0;
    localparam int K_RTY  = 1;
    localparam int K_ERR  = 2;
    localparam int K_NONE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [4:0]  s_adr_i;
    logic [17:0] s_dat_i;
    logic        s_last_i;
    logic        busy_o, done_o, err_o;
    logic [7:0]  count_o;

    always #5 clk = ~clk;

    biquad8_coeff_loader_if bus ();

    biquad8_coeff_loader #(
        .UPDATE_ON_LAST (1'b1),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb        (bus.master),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_adr_i   (s_adr_i),
        .s_dat_i   (s_dat_i),
        .s_last_i  (s_last_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .count_o   (count_o)
    );

    int      n_tests = 0;
    int      n_fail  = 0;
    int      n_done  = 0;
    int      n_gap   = 0;
    int      n_cyc   = 0;
    int      lat     = 1;
    bit      ack_stuck = 1'b0;
    int      kinds[$];
    wb_req_t acks[$];
    wb_req_t attempts[$];
    wb_req_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic wb_req_t mk(input int adr, input int dat);
        wb_req_t w;
        w.adr = 7'(adr);
        w.dat = 32'(dat);
        w.sel = 4'hF;
        return w;
    endfunction

    // Slave responder and bus monitor, evaluated away from the active edge
    initial begin : responder
        int wcnt;
        int kind;
        bit prev_stb;
        wcnt = 0; kind = K_ACK; prev_stb = 1'b0;
        bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0;
        bus.wb_dat_i = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (done_o) n_done++;
            if (bus.wb_cyc_o) n_cyc++;
            if (bus.wb_cyc_o && !bus.wb_stb_o) n_gap++;
            if (bus.wb_stb_o && !prev_stb)
                attempts.push_back('{adr: bus.wb_adr_o, dat: bus.wb_dat_o, sel: bus.wb_sel_o});
            prev_stb = bus.wb_stb_o;
            bus.wb_ack_i = ack_stuck;
            bus.wb_err_i = 1'b0;
            bus.wb_rty_i = 1'b0;
            if (!ack_stuck && bus.wb_cyc_o && bus.wb_stb_o && bus.wb_we_o) begin
                if (wcnt == 0) kind = (kinds.size() > 0) ? kinds.pop_front() : K_ACK;
                wcnt++;
                if (wcnt == lat) begin
                    case (kind)
                        K_ACK: begin
                            bus.wb_ack_i = 1'b1;
                            acks.push_back('{adr: bus.wb_adr_o, dat: bus.wb_dat_o, sel: bus.wb_sel_o});
                        end
                        K_RTY:   bus.wb_rty_i = 1'b1;
                        K_ERR:   bus.wb_err_i = 1'b1;
                        default: ;
                    endcase
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [4:0] a, input logic [17:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        s_valid_i = 1'b1; s_adr_i = a; s_dat_i = d; s_last_i = l;
        for (int i = 0; i < 500 && !ok; i++) begin
            if (s_ready_o) ok = 1'b1;
            @(negedge clk);
        end
        s_valid_i = 1'b0; s_last_i = 1'b0;
        if (!ok) chk("beat_accept_timeout", 64'(ok), 64'(1));
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (!busy_o) ok = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_idle"}, 64'(ok), 64'(1));
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_writes(input string tag);
        chk({tag, "_nwr"}, 64'(acks.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < acks.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), 64'(acks[i]), 64'(exp_q[i]));
        acks.delete();
        exp_q.delete();
    endtask

    // Random frame: every beat lands at index*4, then the update write; count = beats (sat 255)
    task automatic rand_frame(input int nb, input string tag);
        int          d0;
        logic [4:0]  idx[$];
        logic [17:0] val[$];
        d0  = n_done;
        lat = int'($urandom_range(4, 1));
        for (int i = 0; i < nb; i++) begin
            idx.push_back(5'($urandom_range(31, 0)));
            val.push_back(18'($urandom));
            if ($urandom_range(3, 0) == 0) kinds.push_back(K_RTY);
            kinds.push_back(K_ACK);
            exp_q.push_back(mk(int'(idx[i]) * 4, int'(val[i])));
        end
        exp_q.push_back(mk(0, 1));
        for (int i = 0; i < nb; i++) send_beat(idx[i], val[i], 1'(i == nb - 1));
        wait_idle(tag);
        chk_writes(tag);
        chk({tag, "_count"}, 64'(count_o), 64'((nb > 255) ? 255 : nb));
        chk({tag, "_done"}, 64'(n_done - d0), 64'(1));
        chk({tag, "_err"}, 64'(err_o), 64'(0));
    endtask

    initial begin : main
        int d0, g0, c0, a0;
        s_valid_i = 1'b0; s_adr_i = '0; s_dat_i = '0; s_last_i = 1'b0;

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cyc",   64'(bus.wb_cyc_o), 64'(0));
        chk("rst_stb",   64'(bus.wb_stb_o), 64'(0));
        chk("rst_we",    64'(bus.wb_we_o),  64'(0));
        chk("rst_adr",   64'(bus.wb_adr_o), 64'(0));
        chk("rst_dat",   64'(bus.wb_dat_o), 64'(0));
        chk("rst_sel",   64'(bus.wb_sel_o), 64'(0));
        chk("rst_ready", 64'(s_ready_o),    64'(0));
        chk("rst_busy",  64'(busy_o),       64'(0));
        chk("rst_done",  64'(done_o),       64'(0));
        chk("rst_err",   64'(err_o),        64'(0));
        chk("rst_count", 64'(count_o),      64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Two-beat frame with update write, ack after 3 cycles
        lat = 3; d0 = n_done;
        send_beat(5'd1, 18'h00123, 1'b0);
        chk("lat_cyc",   64'(bus.wb_cyc_o), 64'(1));
        chk("lat_stb",   64'(bus.wb_stb_o), 64'(1));
        chk("lat_we",    64'(bus.wb_we_o),  64'(1));
        chk("lat_adr",   64'(bus.wb_adr_o), 64'h04);
        chk("lat_dat",   64'(bus.wb_dat_o), 64'h123);
        chk("lat_sel",   64'(bus.wb_sel_o), 64'hF);
        chk("wr_ready",  64'(s_ready_o),    64'(0));
        chk("wr_busy",   64'(busy_o),       64'(1));
        send_beat(5'd2, 18'h3FFFF, 1'b1);
        wait_idle("f2");
        exp_q.push_back(mk(32'h04, 32'h123));
        exp_q.push_back(mk(32'h08, 32'h3FFFF));
        exp_q.push_back(mk(0, 1));
        chk_writes("f2");
        chk("f2_done",  64'(n_done - d0), 64'(1));
        chk("f2_count", 64'(count_o),     64'(2));
        chk("f2_ready", 64'(s_ready_o),   64'(1));

        // Retry on the first attempt of a single-beat frame
        lat = 2; d0 = n_done; g0 = n_gap;
        attempts.delete();
        kinds.push_back(K_RTY);
        send_beat(5'd4, 18'h00055, 1'b1);
        wait_idle("rty");
        chk("rty_gap",  64'(n_gap - g0),     64'(1));
        chk("rty_natt", 64'(attempts.size()), 64'(3));
        if (attempts.size() >= 2) begin
            chk("rty_att0", 64'(attempts[0]), 64'(mk(32'h10, 32'h55)));
            chk("rty_att1", 64'(attempts[1]), 64'(mk(32'h10, 32'h55)));
        end
        exp_q.push_back(mk(32'h10, 32'h55));
        exp_q.push_back(mk(0, 1));
        chk_writes("rty");
        chk("rty_count", 64'(count_o),     64'(1));
        chk("rty_done",  64'(n_done - d0), 64'(1));

        // Error on beat 1 of a 4-beat frame: remaining beats drained
        lat = 1; d0 = n_done;
        kinds.push_back(K_ERR);
        send_beat(5'd3, 18'h00AAA, 1'b0);
        send_beat(5'd5, 18'h00BBB, 1'b0);
        chk("drain_busy", 64'(busy_o), 64'(1));
        chk("drain_err",  64'(err_o),  64'(1));
        a0 = attempts.size(); c0 = n_cyc;
        send_beat(5'd6, 18'h00CCC, 1'b0);
        send_beat(5'd7, 18'h00DDD, 1'b1);
        wait_idle("drain");
        chk("drain_natt",  64'(attempts.size()), 64'(a0));
        chk("drain_ncyc",  64'(n_cyc - c0),      64'(0));
        chk("drain_done",  64'(n_done - d0),     64'(0));
        chk("drain_err2",  64'(err_o),           64'(1));
        chk("drain_ready", 64'(s_ready_o),       64'(1));
        chk_writes("drain");

        // Next frame's first beat clears the sticky error
        rand_frame(3, "rnd0");

        // Reset in the middle of a stuck write
        lat = 1;
        kinds.push_back(K_ACK);
        kinds.push_back(K_NONE);
        send_beat(5'd8, 18'h01111, 1'b0);
        send_beat(5'd9, 18'h02222, 1'b0);
        repeat (3) @(negedge clk);
        chk("mid_cyc",   64'(bus.wb_cyc_o), 64'(1));
        chk("mid_count", 64'(count_o),      64'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_cyc",   64'(bus.wb_cyc_o), 64'(0));
        chk("mrst_stb",   64'(bus.wb_stb_o), 64'(0));
        chk("mrst_count", 64'(count_o),      64'(0));
        chk("mrst_ready", 64'(s_ready_o),    64'(0));
        chk("mrst_busy",  64'(busy_o),       64'(0));
        rst = 1'b0;
        acks.delete();
        kinds.delete();
        d0 = n_done;
        send_beat(5'd7, 18'h03333, 1'b1);
        wait_idle("post");
        exp_q.push_back(mk(32'h1C, 32'h3333));
        exp_q.push_back(mk(0, 1));
        chk_writes("post");
        chk("post_count", 64'(count_o),     64'(1));
        chk("post_done",  64'(n_done - d0), 64'(1));

        // Ack held high while idle must be ignored
        d0 = n_done; c0 = n_cyc;
        ack_stuck = 1'b1;
        repeat (10) @(negedge clk);
        chk("stuck_count", 64'(count_o),     64'(1));
        chk("stuck_busy",  64'(busy_o),      64'(0));
        chk("stuck_cyc",   64'(n_cyc - c0),  64'(0));
        chk("stuck_done",  64'(n_done - d0), 64'(0));
        ack_stuck = 1'b0;
        repeat (2) @(negedge clk);

        // Randomized frames, then a frame long enough to saturate count_o
        for (int f = 0; f < 6; f++)
            rand_frame(int'($urandom_range(5, 1)), $sformatf("rnd%0d", f + 1));
        rand_frame(256, "sat");

`ifdef BIQUAD8_LOADER_TIMEOUT_EN
        // No response at all: bus is abandoned after the timeout and flagged as an error
        kinds.delete();
        kinds.push_back(K_NONE);
        d0 = n_done; c0 = n_cyc;
        send_beat(5'd2, 18'h00001, 1'b1);
        wait_idle("to");
        chk("to_ncyc", 64'(n_cyc - c0),  64'(TB_TIMEOUT));
        chk("to_err",  64'(err_o),       64'(1));
        chk("to_done", 64'(n_done - d0), 64'(0));
        chk_writes("to");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
